// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencer: opcodes, FSM states,
// exception causes, ALU operation codes and the opcode class record.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_EXC    = 3'd5
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_OVF  = 2'd1;
  localparam logic [1:0] CAUSE_ILL  = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic rtype;
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic illegal;
  } op_class_t;

  // Word offset of a branch: sign-extended immediate scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode-to-class decode shared by the FSM and enable logic.
// Exactly one class bit is set for any opcode.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_class_t  class_o
);

  // One-hot class selection; anything unlisted is illegal.
  always_comb begin
    class_o = '0;
    case (opcode_i)
      OP_RTYPE: class_o.rtype   = 1'b1;
      OP_ADDI:  class_o.addi    = 1'b1;
      OP_LW:    class_o.lw      = 1'b1;
      OP_SW:    class_o.sw      = 1'b1;
      OP_BEQ:   class_o.beq     = 1'b1;
      OP_J:     class_o.j       = 1'b1;
      default:  class_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR, EPC and CAUSE,
// with branch/jump, PC load override and precise overflow/illegal exceptions.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned     PC_W       = 8,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] EXC_VECTOR = {{(PC_W-2){1'b1}}, 2'b00}
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            SYS_load,
  input  logic [PC_W-1:0] SYS_pc_val,
  input  logic [31:0]     imem_instr,
  input  logic            alu_zero,
  input  logic            alu_ovf,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ir,
  output logic [PC_W-1:0] epc,
  output logic [1:0]      cause,
  output logic [2:0]      state,
  output logic            ir_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            alu_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem2reg,
  output logic [1:0]      alu_op
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [1:0]      cause_q, cause_d;

  op_class_t       op_s;
  logic [PC_W-1:0] pc_plus4_s;
  logic [PC_W-1:0] br_target_s;
  logic [PC_W-1:0] j_target_s;

  mc_decode u_decode (
    .opcode_i (ir_q[31:26]),
    .class_o  (op_s)
  );

  // PC is constant through FETCH..EXEC, so all targets derive from pc_q.
  assign pc_plus4_s  = pc_q + PC_W'(32'd4);
  assign br_target_s = PC_W'(32'(pc_plus4_s) + branch_offset(ir_q[15:0]));
  assign j_target_s  = PC_W'((32'(pc_plus4_s) & 32'hF000_0000) |
                             {4'b0000, ir_q[25:0], 2'b00});

  // Architectural state register with asynchronous reset.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0000;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and Moore enable decode; a PC load abandons the instruction.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    alu_src   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem2reg   = 1'b0;
    alu_op    = ALU_ADD;
    if (SYS_load) begin
      pc_d    = SYS_pc_val;
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          // Reset holds state at FETCH; keep the IR enable quiet meanwhile.
          ir_write = ~SYS_reset;
          ir_d     = imem_instr;
          state_d  = ST_DECODE;
        end
        ST_DECODE: begin
          state_d = op_s.illegal ? ST_EXC : ST_EXEC;
        end
        ST_EXEC: begin
          if (op_s.rtype || op_s.addi) begin
            alu_op  = op_s.rtype ? ALU_FUNCT : ALU_ADD;
            reg_dst = op_s.rtype;
            alu_src = op_s.addi;
            state_d = alu_ovf ? ST_EXC : ST_WB;
          end else if (op_s.lw || op_s.sw) begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
            state_d = ST_MEM;
          end else if (op_s.beq) begin
            alu_op  = ALU_SUB;
            pc_d    = alu_zero ? br_target_s : pc_plus4_s;
            state_d = ST_FETCH;
          end else if (op_s.j) begin
            pc_d    = j_target_s;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_EXC;
          end
        end
        ST_MEM: begin
          if (op_s.lw) begin
            mem_read = 1'b1;
            state_d  = ST_WB;
          end else if (op_s.sw) begin
            mem_write = 1'b1;
            pc_d      = pc_plus4_s;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_WB: begin
          reg_write = 1'b1;
          mem2reg   = op_s.lw;
          reg_dst   = op_s.rtype;
          pc_d      = pc_plus4_s;
          state_d   = ST_FETCH;
        end
        ST_EXC: begin
          epc_d   = pc_q;
          cause_d = op_s.illegal ? CAUSE_ILL : CAUSE_OVF;
          pc_d    = EXC_VECTOR;
          state_d = ST_FETCH;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  assign pc    = pc_q;
  assign ir    = ir_q;
  assign epc   = epc_q;
  assign cause = cause_q;
  assign state = state_q;

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Parametrised multi-cycle sequencer for the MIPS-subset core. It owns PC, IR, EPC and CAUSE, and steps every instruction through a FETCH/DECODE/EXEC/MEM/WB state machine. It drives the enables for the shared IMEM, register file, ALU and DMEM, so one ALU and one memory port serve a whole instruction over several cycles. It adds what the single-cycle core lacks: working branch and jump, a PC load override, and precise overflow and illegal-opcode exceptions with EPC capture.

## Interface
- PC_W, 8: PC/EPC width; all PC arithmetic is modulo 2^PC_W.
- RESET_PC, 0: PC value after reset.
- EXC_VECTOR, 2^PC_W-4: PC loaded on an exception.
- SYS_clk  in  1  clock; every register updates on the rising edge.
- SYS_reset  in  1  reset, asynchronous, active-high.
- SYS_load  in  1  synchronous PC override.
- SYS_pc_val  in  PC_W  value loaded when SYS_load is high.
- imem_instr  in  32  IMEM read data at address pc.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- alu_ovf  in  1  ALU signed-overflow flag, valid in EXEC.
- pc  out  PC_W  current PC.
- ir  out  32  latched instruction.
- epc  out  PC_W  PC of the last faulting instruction.
- cause  out  2  0 none, 1 overflow, 2 illegal opcode.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, EXC=5.
- ir_write, reg_write, reg_dst, alu_src, mem_read, mem_write, mem2reg  out  1 each  datapath enables.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.

## Operation
- Supported opcodes: R-type 000000, addi 001000, lw 100011, sw 101011, beq 000100, j 000010. Any other opcode is illegal.
- FETCH: ir_write=1 and ir<=imem_instr; next state DECODE.
- DECODE: an illegal opcode goes to EXC with cause 2; every other opcode goes to EXEC.
- EXEC, per opcode:
  - R-type: alu_op=10, reg_dst=1.
  - addi: alu_src=1, alu_op=00.
  - lw/sw: alu_src=1, alu_op=00; next state MEM.
  - beq: alu_op=01. pc<=pc+4+(sext(ir[15:0])<<2) if alu_zero, else pc+4; next state FETCH.
  - j: pc<={(pc+4) upper bits, ir[25:0],2'b00} truncated to PC_W; next state FETCH.
  - R-type/addi: alu_ovf=1 goes to EXC with cause 1, otherwise WB.
- MEM:
  - lw: mem_read=1; next state WB.
  - sw: mem_write=1, pc<=pc+4; next state FETCH.
- WB: reg_write=1, mem2reg=1 for lw only, reg_dst=1 for R-type only; pc<=pc+4; next state FETCH.
- EXC: epc<=pc (the faulting instruction's PC), cause latched, pc<=EXC_VECTOR; next state FETCH. No register or memory write occurs for the faulting instruction.
- Enables are Moore outputs decoded from state and ir[31:26]; every unnamed enable is 0.
- SYS_load, in any state: pc<=SYS_pc_val and state<=FETCH. epc and cause are unchanged, and any in-flight instruction is abandoned with no write. SYS_reset has priority over SYS_load.

## Timing
- Reset values: pc=RESET_PC, ir=0, epc=0, cause=0, state=FETCH, all enables 0. Reset mid-instruction aborts it immediately.
- Cycles per instruction: j 3, beq 3, sw 4, R-type/addi 4, lw 5.
- Exceptions: illegal opcode costs 3 cycles to the vector fetch, overflow costs 4.
- pc changes only on the exit edge of EXEC (beq/j), MEM (sw), WB or EXC. pc is stable through FETCH..EXEC, so IMEM data and branch arithmetic use a constant PC.
- PC wrap: pc=2^PC_W-4 followed by +4 gives 0. Branch targets wrap the same way.
- cause holds its value until the next exception or reset.

## Structure
- Package mc_pkg: opcode localparams, state encoding, cause codes, alu_op codes.
- Sub-module mc_decode: combinational opcode-to-class decode (rtype, addi, lw, sw, beq, j, illegal). Used by the FSM and by the enable logic.

## Test plan
- Reset then addi $1,$0,5 (0x20010005): states 0→1→2→4→0; reg_write pulses in WB only; pc goes 0→4 after 4 cycles.
- lw then sw at pc=4,8: lw takes 5 cycles with mem_read in MEM and mem2reg+reg_write in WB; sw takes 4 cycles with mem_write only; pc ends at 12.
- beq with offset 3 at pc=12: alu_zero=1 gives pc=28, alu_zero=0 gives pc=16; both in 3 cycles.
- j 0x3F at pc=16, PC_W=8: pc becomes 0xFC; next fetch at 0xFC, then +4 wraps to 0.
- Exceptions: R-type with alu_ovf=1 at pc=20 gives epc=20, cause=1, pc=0xFC, no reg_write; opcode 111111 at pc=24 gives cause=2 from DECODE.
- Interruptions: SYS_load=1 with SYS_pc_val=0x40 during MEM of sw gives no mem_write, next state FETCH, pc=0x40. SYS_reset pulsed mid-EXEC returns all outputs to reset values asynchronously.
